memory_access: RTL and testbench

- MEM stage of the RV32I pipeline. It consumes the EX/MEM register (control word, instruction, ALU result, store data, byte enables, address offset) and drives the data-cache request/response handshake.
- It aligns load data and shifts store data, and asserts MA_stall while an access is outstanding.
- It owns the MEM/WB pipeline register, which also feeds the mem_wb forwarding path back into execute.

---
 rtl/memory_access_pkg.sv | 48 ++++
 rtl/memory_access_if.sv | 22 ++
 rtl/memory_access_load_align.sv | 24 ++
 rtl/memory_access.sv | 133 +++++++++++++
 tb/tb_memory_access.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_access_pkg.sv
// RV32I types shared by the MEM stage: opcodes, funct3 encodings, control word.
package memory_access_pkg;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef enum logic [2:0] {
    slt  = 3'b010,
    sltu = 3'b011
  } arith_funct3_t;

  typedef struct packed {
    rv32i_opcode opcode;
    logic        load_regfile;
    logic [4:0]  rd;
  } rv32i_control_word;

  function automatic logic is_memop(rv32i_opcode op);
    return (op == op_load) || (op == op_store);
  endfunction

endpackage

// File: rtl/memory_access_if.sv
// Data-cache request/response bus between the MEM stage (master) and the cache (slave).
interface memory_access_if;
  import memory_access_pkg::*;

  logic       dmem_read;
  logic       dmem_write;
  rv32i_word  dmem_address;
  rv32i_word  dmem_wdata;
  logic [3:0] dmem_byte_enable;
  rv32i_word  dmem_rdata;
  logic       dmem_resp;

  modport master (
    output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    output dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/memory_access_load_align.sv
// Load lane select and sign/zero extension.
// Latency: combinational. Backpressure: none.
// Misaligned halfword/word offsets are not trapped; the shifted lane is used as-is.
module memory_access_load_align
  import memory_access_pkg::*;
(
  input  rv32i_word  rdata,
  input  logic [1:0] offset,
  input  logic [2:0] funct3,
  output rv32i_word  data
);
  rv32i_word lane;

  always_comb begin
    lane = rdata >> {offset, 3'b000};
    case (load_funct3_t'(funct3))
      lb:      data = {{24{lane[7]}}, lane[7:0]};
      lh:      data = {{16{lane[15]}}, lane[15:0]};
      lbu:     data = {24'b0, lane[7:0]};
      lhu:     data = {16'b0, lane[15:0]};
      default: data = lane;
    endcase
  end
endmodule

// File: rtl/memory_access.sv
// MEM stage: issues data-cache accesses, aligns loads, owns the MEM/WB register.
// Latency: non-memops 1 cycle; a memop answered N cycles after request stalls N+1 cycles.
// Backpressure: MA_stall holds upstream from the memop's first cycle until its response.
module memory_access
  import memory_access_pkg::*;
#(
  parameter int PERF_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  rv32i_control_word   ctrl_word_in,
  input  rv32i_word           instruction_in,
  input  rv32i_word           PC_in,
  input  rv32i_word           alu_in,
  input  rv32i_word           rs2_in,
  input  logic                br_en_in,
  input  logic [3:0]          mem_byte_enable_in,
  input  logic [1:0]          addr_offset_in,
  memory_access_if.master     dmem,
  output logic                MA_stall,
  output rv32i_control_word   mem_wb,
  output rv32i_word           mem_wb_data,
  output rv32i_word           instruction_out,
  output rv32i_word           PC_out,
  output logic [PERF_W-1:0]   load_cnt,
  output logic [PERF_W-1:0]   store_cnt,
  output logic [PERF_W-1:0]   stall_cnt
);
  typedef enum logic {IDLE, BUSY} mem_state_t;

  localparam logic [PERF_W-1:0] CNT_ONE = PERF_W'(1);

  mem_state_t  state;
  logic        read_q, write_q, is_load;
  logic [29:0] addr_q;
  logic [1:0]  off_q;
  logic [2:0]  funct3_q;
  logic [3:0]  be_q;
  rv32i_word   wdata_q, load_data, wb_data_next;
  logic        memop, busy, resp_hit;
  logic [2:0]  funct3;

  assign funct3   = instruction_in[14:12];
  assign memop    = is_memop(ctrl_word_in.opcode);
  assign busy     = (state == BUSY);
  assign resp_hit = busy && dmem.dmem_resp;
  assign MA_stall = busy ? !dmem.dmem_resp : memop;

  // Request is dropped in the response cycle itself, not one cycle later.
  assign dmem.dmem_read        = read_q && !dmem.dmem_resp;
  assign dmem.dmem_write       = write_q && !dmem.dmem_resp;
  assign dmem.dmem_address     = {addr_q, 2'b00};
  assign dmem.dmem_wdata       = wdata_q;
  assign dmem.dmem_byte_enable = be_q;

  memory_access_load_align u_load_align (
    .rdata  (dmem.dmem_rdata),
    .offset (off_q),
    .funct3 (funct3_q),
    .data   (load_data)
  );

  always_comb begin
    wb_data_next = alu_in;
    case (ctrl_word_in.opcode)
      op_load:         wb_data_next = load_data;
      op_jal, op_jalr: wb_data_next = PC_in + 32'd4;
      op_reg, op_imm:
        if (funct3 == slt || funct3 == sltu) wb_data_next = {31'b0, br_en_in};
      default:         wb_data_next = alu_in;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      is_load  <= 1'b0;
      addr_q   <= '0;
      off_q    <= '0;
      funct3_q <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
    end else begin
      unique case (state)
        IDLE: if (memop) begin
          state    <= BUSY;
          is_load  <= (ctrl_word_in.opcode == op_load);
          read_q   <= (ctrl_word_in.opcode == op_load);
          write_q  <= (ctrl_word_in.opcode == op_store);
          addr_q   <= alu_in[31:2];
          off_q    <= addr_offset_in;
          funct3_q <= funct3;
          wdata_q  <= rs2_in << {addr_offset_in, 3'b000};
          be_q     <= (ctrl_word_in.opcode == op_store) ? mem_byte_enable_in : 4'b0000;
        end
        BUSY: if (dmem.dmem_resp) begin
          state   <= IDLE;
          read_q  <= 1'b0;
          write_q <= 1'b0;
        end
      endcase
    end
  end

  // MEM/WB holds through a stall so a stalled instruction is written back only once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_wb          <= '0;
      mem_wb_data     <= '0;
      instruction_out <= '0;
      PC_out          <= '0;
    end else if (!MA_stall) begin
      mem_wb          <= ctrl_word_in;
      mem_wb_data     <= wb_data_next;
      instruction_out <= instruction_in;
      PC_out          <= PC_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_cnt  <= '0;
      store_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (resp_hit && is_load && load_cnt != '1)   load_cnt  <= load_cnt + CNT_ONE;
      if (resp_hit && !is_load && store_cnt != '1) store_cnt <= store_cnt + CNT_ONE;
      if (MA_stall && stall_cnt != '1)             stall_cnt <= stall_cnt + CNT_ONE;
    end
  end
endmodule

// File: tb/tb_memory_access.sv
// Randomized bench for memory_access against a transaction-level model of stall, request and writeback.
module tb_memory_access;
  import memory_access_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  rv32i_control_word ctrl_word_in;
  rv32i_word         instruction_in, PC_in, alu_in, rs2_in;
  logic              br_en_in;
  logic [3:0]        mem_byte_enable_in;
  logic [1:0]        addr_offset_in;
  logic              MA_stall;
  rv32i_control_word mem_wb;
  rv32i_word         mem_wb_data, instruction_out, PC_out;
  logic [31:0]       load_cnt, store_cnt, stall_cnt;

  memory_access_if dmem();

  memory_access #(.PERF_W(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .ctrl_word_in       (ctrl_word_in),
    .instruction_in     (instruction_in),
    .PC_in              (PC_in),
    .alu_in             (alu_in),
    .rs2_in             (rs2_in),
    .br_en_in           (br_en_in),
    .mem_byte_enable_in (mem_byte_enable_in),
    .addr_offset_in     (addr_offset_in),
    .dmem               (dmem),
    .MA_stall           (MA_stall),
    .mem_wb             (mem_wb),
    .mem_wb_data        (mem_wb_data),
    .instruction_out    (instruction_out),
    .PC_out             (PC_out),
    .load_cnt           (load_cnt),
    .store_cnt          (store_cnt),
    .stall_cnt          (stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;
  int spur_mode = 0;

  // Per-cycle expectations and the model's MEM/WB register and counters.
  logic              exp_stall = 1'b0, exp_read = 1'b0, exp_write = 1'b0;
  rv32i_word         exp_addr, exp_wdata;
  logic [3:0]        exp_be;
  rv32i_control_word m_cw, nxt_cw;
  rv32i_word         m_data, m_instr, m_pc, nxt_data, nxt_instr, nxt_pc;
  logic [31:0]       m_load, m_store, m_stall;
  logic              resp_cycle = 1'b0, cur_load = 1'b0;
  logic [31:0]       read_hi = 0, stall_hi = 0, wb_changes = 0;
  rv32i_word         last_pc = '0, snap_addr = '0, snap_wdata = '0;
  logic [3:0]        snap_be = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rv32i_word load_val(input logic [2:0] f3, input rv32i_word rd, input logic [1:0] off);
    rv32i_word lane;
    int s;
    lane = rd >> (8 * off);
    case (f3)
      3'b000: begin s = $signed(lane[7:0]);  return s; end
      3'b001: begin s = $signed(lane[15:0]); return s; end
      3'b100: return lane & 32'h0000_00FF;
      3'b101: return lane & 32'h0000_FFFF;
      default: return lane;
    endcase
  endfunction

  task automatic reset_model();
    m_cw = '0; m_data = '0; m_instr = '0; m_pc = '0;
    m_load = '0; m_store = '0; m_stall = '0;
  endtask

  task automatic drive(input rv32i_opcode op, input logic [2:0] f3, input rv32i_word pc_v,
                       input rv32i_word alu_v, input rv32i_word rs2_v, input logic br,
                       input logic [3:0] be_v);
    rv32i_word ins;
    ins = $urandom;
    ins[14:12] = f3;
    ins[6:0] = op;
    ctrl_word_in.opcode = op;
    ctrl_word_in.load_regfile = 1'($urandom_range(0, 1));
    ctrl_word_in.rd = 5'($urandom);
    instruction_in = ins;
    PC_in = pc_v; alu_in = alu_v; rs2_in = rs2_v; br_en_in = br;
    mem_byte_enable_in = be_v; addr_offset_in = alu_v[1:0];
    cur_load = (op == op_load);
    exp_addr = alu_v & 32'hFFFF_FFFC;
    exp_wdata = rs2_v << (8 * alu_v[1:0]);
    exp_be = cur_load ? 4'b0000 : be_v;
    nxt_cw = ctrl_word_in; nxt_instr = ins; nxt_pc = pc_v;
    if (op == op_jal || op == op_jalr) nxt_data = pc_v + 4;
    else if ((op == op_imm || op == op_reg) && (f3 == 3'b010 || f3 == 3'b011)) nxt_data = {31'b0, br};
    else nxt_data = alu_v;
    exp_stall = (op == op_load || op == op_store);
    exp_read = 1'b0; exp_write = 1'b0; resp_cycle = 1'b0;
    dmem.dmem_resp = (spur_mode == 1) ? 1'b1 : ($urandom_range(0, 3) == 0);
    dmem.dmem_rdata = $urandom;
  endtask

  task automatic tick();
    @(posedge clk);
    if (exp_stall) m_stall = m_stall + 1;
    if (resp_cycle) begin
      if (cur_load) m_load = m_load + 1;
      else m_store = m_store + 1;
    end
    if (!exp_stall) begin
      m_cw = nxt_cw; m_data = nxt_data; m_instr = nxt_instr; m_pc = nxt_pc;
    end
    #1;
    dmem.dmem_resp = 1'b0;
  endtask

  // Response arrives n cycles after the request first appears.
  task automatic run_instr(input rv32i_opcode op, input logic [2:0] f3, input rv32i_word pc_v,
                           input rv32i_word alu_v, input rv32i_word rs2_v, input logic br,
                           input logic [3:0] be_v, input int n, input rv32i_word rd_v);
    drive(op, f3, pc_v, alu_v, rs2_v, br, be_v);
    if (op == op_load) nxt_data = load_val(f3, rd_v, alu_v[1:0]);
    tick();
    if (op == op_load || op == op_store) begin
      for (int k = 1; k <= n + 1; k++) begin
        exp_read  = cur_load && (k <= n);
        exp_write = !cur_load && (k <= n);
        exp_stall = (k <= n);
        resp_cycle = (k == n + 1);
        dmem.dmem_resp = resp_cycle;
        dmem.dmem_rdata = resp_cycle ? rd_v : $urandom;
        tick();
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("ma_stall", {31'b0, MA_stall}, {31'b0, exp_stall});
      check("dmem_read", {31'b0, dmem.dmem_read}, {31'b0, exp_read});
      check("dmem_write", {31'b0, dmem.dmem_write}, {31'b0, exp_write});
      if (exp_read || exp_write) begin
        check("dmem_address", dmem.dmem_address, exp_addr);
        check("dmem_wdata", dmem.dmem_wdata, exp_wdata);
        check("dmem_byte_enable", {28'b0, dmem.dmem_byte_enable}, {28'b0, exp_be});
      end
      check("mem_wb", {19'b0, mem_wb}, {19'b0, m_cw});
      check("mem_wb_data", mem_wb_data, m_data);
      check("instruction_out", instruction_out, m_instr);
      check("pc_out", PC_out, m_pc);
      check("load_cnt", load_cnt, m_load);
      check("store_cnt", store_cnt, m_store);
      check("stall_cnt", stall_cnt, m_stall);
      if (dmem.dmem_read) read_hi = read_hi + 1;
      if (MA_stall) stall_hi = stall_hi + 1;
      if (dmem.dmem_write) begin
        snap_addr = dmem.dmem_address; snap_wdata = dmem.dmem_wdata; snap_be = dmem.dmem_byte_enable;
      end
      if (PC_out != last_pc) wb_changes = wb_changes + 1;
      last_pc = PC_out;
    end
  end

  initial begin
    rv32i_opcode ops[8];
    logic [2:0] lf3[5];
    rv32i_opcode op;
    logic [2:0] f3;
    ops = '{op_load, op_store, op_imm, op_reg, op_jal, op_jalr, op_lui, op_br};
    lf3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    reset_model();
    drive(op_imm, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 4'h0);
    dmem.dmem_resp = 1'b0;
    #2;
    check("rst_dmem_read", {31'b0, dmem.dmem_read}, 32'd0);
    check("rst_dmem_write", {31'b0, dmem.dmem_write}, 32'd0);
    check("rst_mem_wb_data", mem_wb_data, 32'd0);
    check("rst_instruction_out", instruction_out, 32'd0);
    check("rst_pc_out", PC_out, 32'd0);
    check("rst_mem_wb", {19'b0, mem_wb}, 32'd0);
    check("rst_counters", load_cnt | store_cnt | stall_cnt, 32'd0);
    #10 rst = 1'b1;
    chk_en = 1'b1;
    run_instr(op_imm, 3'b000, 32'h0000_00F0, 32'h11, 32'h0, 1'b0, 4'h0, 1, 32'h0);

    // lw with a 3-cycle response
    read_hi = 0; stall_hi = 0;
    run_instr(op_load, 3'b010, 32'h100, 32'h1000_0008, $urandom, 1'b0, 4'hF, 3, 32'hDEAD_BEEF);
    check("lw_data", mem_wb_data, 32'hDEAD_BEEF);
    check("lw_load_cnt", load_cnt, 32'd1);
    check("lw_stall_cnt", stall_cnt, 32'd4);
    check("lw_read_cycles", read_hi, 32'd3);
    check("lw_stall_cycles", stall_hi, 32'd4);

    run_instr(op_load, 3'b000, 32'h104, 32'h1000_0013, 32'h0, 1'b0, 4'h8, 1, 32'h8012_3456);
    check("lb_off3", mem_wb_data, 32'hFFFF_FF80);
    run_instr(op_load, 3'b100, 32'h108, 32'h1000_0013, 32'h0, 1'b0, 4'h8, 2, 32'h8012_3456);
    check("lbu_off3", mem_wb_data, 32'h0000_0080);
    run_instr(op_load, 3'b101, 32'h10C, 32'h1000_0012, 32'h0, 1'b0, 4'hC, 1, 32'h8012_3456);
    check("lhu_off2", mem_wb_data, 32'h0000_8012);

    run_instr(op_store, 3'b000, 32'h110, 32'h2000_0002, 32'h0000_00AB, 1'b0, 4'b0100, 2, 32'h0);
    check("sb_wdata", snap_wdata, 32'h00AB_0000);
    check("sb_be", {28'b0, snap_be}, 32'h4);
    check("sb_address", snap_addr, 32'h2000_0000);

    stall_hi = 0;
    run_instr(op_jal, 3'b000, 32'h60, $urandom, $urandom, 1'b0, 4'h0, 1, 32'h0);
    check("jal_link", mem_wb_data, 32'h64);
    check("jal_no_stall", stall_hi, 32'd0);
    run_instr(op_imm, 3'b010, 32'h64, 32'h5, 32'h0, 1'b1, 4'h0, 1, 32'h0);
    check("slti_result", mem_wb_data, 32'd1);

    // Reset while a load is outstanding, then a stale response in IDLE
    drive(op_load, 3'b010, 32'h200, 32'h3000_0000, 32'h0, 1'b0, 4'hF);
    dmem.dmem_resp = 1'b0;
    tick();
    chk_en = 1'b0;
    #1 check("busy_read_before_rst", {31'b0, dmem.dmem_read}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check("abort_dmem_read", {31'b0, dmem.dmem_read}, 32'd0);
    check("abort_dmem_write", {31'b0, dmem.dmem_write}, 32'd0);
    check("abort_mem_wb_data", mem_wb_data, 32'd0);
    check("abort_pc_out", PC_out, 32'd0);
    check("abort_instruction_out", instruction_out, 32'd0);
    check("abort_counters", load_cnt | store_cnt | stall_cnt, 32'd0);
    reset_model();
    #3 rst = 1'b1;
    chk_en = 1'b1;
    spur_mode = 1;
    run_instr(op_imm, 3'b000, 32'h300, 32'h7, 32'h0, 1'b0, 4'h0, 1, 32'h0);
    spur_mode = 0;
    check("stale_resp_stall_cnt", stall_cnt, 32'd0);
    check("stale_resp_load_cnt", load_cnt, 32'd0);

    // sw then lw back to back, single-cycle responses
    last_pc = PC_out; wb_changes = 0; stall_hi = 0;
    run_instr(op_store, 3'b010, 32'h400, 32'h4000_0010, $urandom, 1'b0, 4'hF, 1, 32'h0);
    check("sw_stall_cycles", stall_hi, 32'd2);
    stall_hi = 0;
    run_instr(op_load, 3'b010, 32'h404, 32'h4000_0010, 32'h0, 1'b0, 4'hF, 1, 32'h1234_5678);
    check("lw2_stall_cycles", stall_hi, 32'd2);
    run_instr(op_imm, 3'b000, 32'h408, 32'h9, 32'h0, 1'b0, 4'h0, 1, 32'h0);
    check("wb_once_each", wb_changes, 32'd2);
    check("pair_store_cnt", store_cnt, 32'd1);
    check("pair_load_cnt", load_cnt, 32'd1);

    for (int i = 0; i < 200; i++) begin
      op = ops[$urandom_range(0, 7)];
      if (op == op_load) f3 = lf3[$urandom_range(0, 4)];
      else if (op == op_store) f3 = 3'($urandom_range(0, 2));
      else f3 = 3'($urandom_range(0, 7));
      run_instr(op, f3, $urandom & 32'hFFFF_FFFC, $urandom, $urandom, 1'($urandom_range(0, 1)),
                4'($urandom), $urandom_range(1, 4), $urandom);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
